bbox_encoder: RTL and testbench



---
 rtl/bbox_pkg.sv | 19 +
 rtl/bbox_div_serial.sv | 78 +++++++
 rtl/bbox_encoder.sv | 129 ++++++++++++
 tb/tb_bbox_encoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// Shared definitions for the bounding-box encode and decode path.
// Fixed-point shift, encoder state encoding and quotient saturation value.
package bbox_pkg;

  localparam int FRAC_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_W = 2'd1,
    DIV_H = 2'd2,
    DONE  = 2'd3
  } state_t;

  // All-ones value of an n-bit field (n <= 63).
  function automatic logic [63:0] sat_value(input int unsigned n);
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/bbox_div_serial.sv
// Restoring serial divider: one quotient bit per cycle, MSB first, floor result.
// Start edge performs the first iteration; done pulses the cycle after the last of N+FRAC iterations.
module bbox_div_serial import bbox_pkg::*; #(
  parameter int N    = 16,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N+FRAC-1:0]   dividend,
  input  logic [N-1:0]        divisor,
  output logic                busy,
  output logic                done,
  output logic [N+FRAC-1:0]   quotient,
  output logic                div0
);

  localparam int W  = N + FRAC;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  dvd_q, quo_q;
  logic [N-1:0]  dsr_q, rem_q;
  logic [CW-1:0] cnt_q;
  logic          done_q, div0_q;

  logic [W-1:0]  src_dvd, src_quo;
  logic [N-1:0]  src_dsr, src_rem;
  logic [N:0]    trial, diff;
  logic          qbit;

  // Start merges the operand load with the first iteration.
  always_comb begin
    src_dvd = start ? dividend : dvd_q;
    src_dsr = start ? divisor  : dsr_q;
    src_rem = start ? '0       : rem_q;
    src_quo = start ? '0       : quo_q;
    trial   = {src_rem, src_dvd[W-1]};
    diff    = trial;
    qbit    = 1'b0;
    if (trial >= {1'b0, src_dsr}) begin
      diff = trial - {1'b0, src_dsr};
      qbit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start || cnt_q != '0) begin
        dvd_q <= {src_dvd[W-2:0], 1'b0};
        dsr_q <= src_dsr;
        rem_q <= diff[N-1:0];
        quo_q <= {src_quo[W-2:0], qbit};
        if (start) begin
          cnt_q  <= CW'(W - 1);
          div0_q <= (divisor == '0);
        end else begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) done_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = done_q;
  assign quotient = quo_q;
  assign div0     = div0_q;

endmodule

// File: rtl/bbox_encoder.sv
// Encodes a box into (tx, ty, tw, th); tw/th via one shared serial divider used twice.
// Result valid 1+2*(N+FRAC) edges after capture; held in DONE until out_ready, no input overlap.
module bbox_encoder import bbox_pkg::*; #(
  parameter int N    = 16,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] bx,
  input  logic [N-1:0] by,
  input  logic [N-1:0] bw,
  input  logic [N-1:0] bh,
  input  logic [N-1:0] anchor_w,
  input  logic [N-1:0] anchor_h,
  input  logic [N-1:0] cx,
  input  logic [N-1:0] cy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] tx,
  output logic [N-1:0] ty,
  output logic [N-1:0] tw,
  output logic [N-1:0] th,
  output logic         div_err,
  output logic         sat
);

  localparam int W = N + FRAC;
  localparam logic [N-1:0] SAT = N'(sat_value(N));

  state_t       state;
  logic [N-1:0] bw_q, bh_q, aw_q, ah_q;
  logic         kick;

  logic         div_start, div_busy, div_done, div_zero;
  logic [W-1:0] div_dividend, div_quo;
  logic [N-1:0] div_divisor;

  logic [N-1:0] res;
  logic         res_err, res_sat;

  // Width division launches from the capture kick; height launches on width completion.
  assign div_start    = (kick && !div_busy) || (state == DIV_W && div_done);
  assign div_dividend = kick ? {bw_q, {FRAC{1'b0}}} : {bh_q, {FRAC{1'b0}}};
  assign div_divisor  = kick ? aw_q : ah_q;

  bbox_div_serial #(.N(N), .FRAC(FRAC)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .div0     (div_zero)
  );

  // A zero divisor takes precedence and never reports saturation.
  always_comb begin
    res     = div_quo[N-1:0];
    res_err = 1'b0;
    res_sat = 1'b0;
    if (div_zero) begin
      res     = SAT;
      res_err = 1'b1;
    end else if (|div_quo[W-1:N]) begin
      res     = SAT;
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      kick      <= 1'b0;
      bw_q      <= '0;
      bh_q      <= '0;
      aw_q      <= '0;
      ah_q      <= '0;
      tx        <= '0;
      ty        <= '0;
      tw        <= '0;
      th        <= '0;
      div_err   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      kick <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          bw_q     <= bw;
          bh_q     <= bh;
          aw_q     <= anchor_w;
          ah_q     <= anchor_h;
          tx       <= bx - cx;
          ty       <= by - cy;
          div_err  <= 1'b0;
          sat      <= 1'b0;
          kick     <= 1'b1;
          in_ready <= 1'b0;
          state    <= DIV_W;
        end
        DIV_W: if (div_done) begin
          tw      <= res;
          div_err <= div_err | res_err;
          sat     <= sat | res_sat;
          state   <= DIV_H;
        end
        DIV_H: if (div_done) begin
          th        <= res;
          div_err   <= div_err | res_err;
          sat       <= sat | res_sat;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_encoder.sv
// Scoreboard bench for bbox_encoder: expected targets queued at capture, compared when out_valid rises.
module tb_bbox_encoder;

  typedef struct packed {
    logic [15:0] bx, by, bw, bh, aw, ah, cx, cy;
  } box_t;

  typedef struct packed {
    logic [15:0] tx, ty, tw, th;
    logic        err, sat;
  } exp_t;

  localparam int LAT = 53;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bx = '0, by = '0, bw = '0, bh = '0;
  logic [15:0] anchor_w = '0, anchor_h = '0, cx = '0, cy = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] tx, ty, tw, th;
  logic        div_err, sat;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cap_cyc = 0;
  exp_t sb[$];

  bbox_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .bx(bx), .by(by), .bw(bw), .bh(bh),
    .anchor_w(anchor_w), .anchor_h(anchor_h), .cx(cx), .cy(cy),
    .out_valid(out_valid), .out_ready(out_ready),
    .tx(tx), .ty(ty), .tw(tw), .th(th),
    .div_err(div_err), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference for one target: {err, sat, value}.
  function automatic logic [17:0] ref_div(input logic [15:0] num, input logic [15:0] den);
    logic [25:0] q;
    if (den == 16'd0) return {1'b1, 1'b0, 16'hFFFF};
    q = {num, 10'd0} / {10'd0, den};
    if (q > 26'h00FFFF) return {1'b0, 1'b1, 16'hFFFF};
    return {2'b00, q[15:0]};
  endfunction

  function automatic exp_t model(input box_t b);
    exp_t        e;
    logic [17:0] rw, rh;
    rw    = ref_div(b.bw, b.aw);
    rh    = ref_div(b.bh, b.ah);
    e.tx  = b.bx - b.cx;
    e.ty  = b.by - b.cy;
    e.tw  = rw[15:0];
    e.th  = rh[15:0];
    e.err = rw[17] | rh[17];
    e.sat = rw[16] | rh[16];
    return e;
  endfunction

  task automatic drive(input box_t b);
    bx = b.bx; by = b.by; bw = b.bw; bh = b.bh;
    anchor_w = b.aw; anchor_h = b.ah; cx = b.cx; cy = b.cy;
  endtask

  task automatic send(input box_t b, input exp_t e, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait: in_ready=%b required 1", in_ready);
    end
    drive(b);
    in_valid = 1'b1;
    @(posedge clk); #1;
    cap_cyc  = cyc;
    in_valid = 1'b0;
    drive(box_t'({$urandom, $urandom, $urandom, $urandom}));
    if (push) sb.push_back(e);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL out_wait: out_valid=%b queued=%0d required 1 and >0", out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (cyc - cap_cyc !== LAT) begin
      errors++; $display("FAIL latency: got %0d required %0d", cyc - cap_cyc, LAT);
    end
    checks++;
    if (tx !== e.tx) begin errors++; $display("FAIL tx: got %h required %h", tx, e.tx); end
    checks++;
    if (ty !== e.ty) begin errors++; $display("FAIL ty: got %h required %h", ty, e.ty); end
    checks++;
    if (tw !== e.tw) begin errors++; $display("FAIL tw: got %h required %h", tw, e.tw); end
    checks++;
    if (th !== e.th) begin errors++; $display("FAIL th: got %h required %h", th, e.th); end
    checks++;
    if (div_err !== e.err) begin errors++; $display("FAIL div_err: got %b required %b", div_err, e.err); end
    checks++;
    if (sat !== e.sat) begin errors++; $display("FAIL sat: got %b required %b", sat, e.sat); end
    repeat (hold) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {tx, ty, tw, th, div_err, sat} !== e) begin
        errors++;
        $display("FAIL hold: valid=%b ready=%b out=%h required 1 0 %h",
                 out_valid, in_ready, {tx, ty, tw, th, div_err, sat}, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {tx, ty, tw, th, div_err, sat} !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b out=%h required 1 0 0",
               in_ready, out_valid, {tx, ty, tw, th, div_err, sat});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send('{bx:50, by:70, bw:2048, bh:512, aw:1024, ah:256, cx:20, cy:30},
         '{tx:30, ty:40, tw:2048, th:2048, err:0, sat:0}, 1'b1);
    collect(0);
  endtask

  task automatic test_wrap_floor();
    send('{bx:5, by:100, bw:3, bh:1, aw:7, ah:1, cx:10, cy:1},
         '{tx:16'hFFFB, ty:99, tw:438, th:1024, err:0, sat:0}, 1'b1);
    collect(0);
  endtask

  task automatic test_div0();
    send('{bx:1, by:1, bw:100, bh:512, aw:0, ah:512, cx:0, cy:0},
         '{tx:1, ty:1, tw:16'hFFFF, th:1024, err:1, sat:0}, 1'b1);
    collect(0);
  endtask

  task automatic test_sat();
    send('{bx:0, by:0, bw:16'hFFFF, bh:1, aw:1, ah:2, cx:0, cy:0},
         '{tx:0, ty:0, tw:16'hFFFF, th:512, err:0, sat:1}, 1'b1);
    collect(0);
    send('{bx:50, by:70, bw:2048, bh:512, aw:1024, ah:256, cx:20, cy:30},
         '{tx:30, ty:40, tw:2048, th:2048, err:0, sat:0}, 1'b1);
    collect(0);
  endtask

  task automatic test_backpressure();
    box_t b2;
    b2 = '{bx:9, by:8, bw:700, bh:900, aw:100, ah:300, cx:4, cy:10};
    send('{bx:50, by:70, bw:2048, bh:512, aw:1024, ah:256, cx:20, cy:30},
         '{tx:30, ty:40, tw:2048, th:2048, err:0, sat:0}, 1'b1);
    // Offer the next box for the whole operation; it must wait until DONE exits.
    drive(b2);
    in_valid = 1'b1;
    collect(10);
    @(posedge clk); #1;
    cap_cyc  = cyc;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL offered_capture: in_ready=%b required 0", in_ready);
    end
    sb.push_back(model(b2));
    collect(0);
  endtask

  task automatic test_reset_mid();
    send('{bx:3, by:3, bw:5000, bh:6000, aw:30, ah:40, cx:1, cy:1}, '0, 1'b0);
    repeat (35) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {tx, ty, tw, th, div_err, sat} !== '0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b out=%h required 1 0 0",
               in_ready, out_valid, {tx, ty, tw, th, div_err, sat});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
  endtask

  task automatic test_back_to_back();
    box_t b;
    for (int i = 0; i < 5; i++) begin
      b = '{bx:16'($urandom), by:16'($urandom), bw:16'($urandom_range(0, 4000)),
            bh:16'($urandom), aw:16'($urandom_range(0, 600)), ah:16'($urandom_range(1, 70000 % 65536)),
            cx:16'($urandom), cy:16'($urandom)};
      send(b, model(b), 1'b1);
      collect(i % 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_floor();
    test_div0();
    test_sat();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
